// File: rtl/clk_gate_en_ctrl.sv
// ---------------------------------------------------------------------------
// clk_gate_en_ctrl
// Produces the enable for a downstream AND-type clock gate
// (o_clk = i_clk & o_en).
//
// A level request is turned into a glitch-free enable. The block waits
// WAKE_CYC ungated cycles before acknowledging. It also holds the gate open
// for a programmable number of idle cycles before closing it.
//
// All state moves on the rising edge. The enable seen by the gate is
// re-registered on the falling edge, so it only ever changes while i_clk is
// low and cannot clip a high phase.
//
// WAKE_CYC must lie in 1..15; the wake counter is four bits wide.
// ---------------------------------------------------------------------------
module clk_gate_en_ctrl #(
  parameter int IDLE_CNT_W = 8,
  parameter int WAKE_CYC   = 2,
  parameter bit RESET_ON   = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_force_on,
  input  logic [IDLE_CNT_W-1:0] i_idle_cfg,
  output logic                  o_en,
  output logic                  o_ack,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_WAKE      = 2'd1,
    ST_ON        = 2'd2,
    ST_IDLE_WAIT = 2'd3
  } state_t;

  localparam state_t                RESET_STATE = RESET_ON ? ST_ON : ST_OFF;
  localparam logic [3:0]            WAKE_INIT   = 4'(WAKE_CYC - 1);
  localparam logic [IDLE_CNT_W-1:0] IDLE_ONE    = IDLE_CNT_W'(1);

  state_t                r_state;
  state_t                w_stateNext;
  logic [3:0]            r_wakeCnt;
  logic [3:0]            w_wakeCntNext;
  logic [IDLE_CNT_W-1:0] r_idleCnt;
  logic [IDLE_CNT_W-1:0] w_idleCntNext;
  logic                  w_want;
  logic                  w_enInt;
  logic                  w_ack;
  logic                  r_en;

  assign w_want = i_req | i_force_on;

  // State and counter register: a synchronous reset restores the reset state from any state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= RESET_STATE;
      r_wakeCnt <= '0;
      r_idleCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_wakeCnt <= w_wakeCntNext;
      r_idleCnt <= w_idleCntNext;
    end
  end

  // Next-state logic: WAKE always runs to completion, and the idle counter is only loaded on entry to IDLE_WAIT.
  always_comb begin
    w_stateNext   = r_state;
    w_wakeCntNext = r_wakeCnt;
    w_idleCntNext = r_idleCnt;
    case (r_state)
      ST_OFF: begin
        if (w_want) begin
          w_stateNext   = ST_WAKE;
          w_wakeCntNext = WAKE_INIT;
        end
      end
      ST_WAKE: begin
        if (r_wakeCnt == 4'd0) begin
          w_stateNext = ST_ON;
        end else begin
          w_wakeCntNext = r_wakeCnt - 4'd1;
        end
      end
      ST_ON: begin
        if (!w_want) begin
          w_stateNext   = ST_IDLE_WAIT;
          w_idleCntNext = i_idle_cfg;
        end
      end
      ST_IDLE_WAIT: begin
        if (w_want) begin
          w_stateNext = ST_ON;
        end else if (r_idleCnt == '0) begin
          w_stateNext = ST_OFF;
        end else begin
          w_idleCntNext = r_idleCnt - IDLE_ONE;
        end
      end
      default: begin
        w_stateNext = ST_OFF;
      end
    endcase
  end

  // Output decode: the enable is open in every state except OFF; the ack is high only once settled (ON/IDLE_WAIT).
  always_comb begin
    w_enInt = 1'b0;
    w_ack   = 1'b0;
    case (r_state)
      ST_OFF:       begin w_enInt = 1'b0; w_ack = 1'b0; end
      ST_WAKE:      begin w_enInt = 1'b1; w_ack = 1'b0; end
      ST_ON:        begin w_enInt = 1'b1; w_ack = 1'b1; end
      ST_IDLE_WAIT: begin w_enInt = 1'b1; w_ack = 1'b1; end
      default:      begin w_enInt = 1'b0; w_ack = 1'b0; end
    endcase
  end

  // Falling-edge launch of the gate enable so it only changes while i_clk is low.
  always_ff @(negedge i_clk) begin
    r_en <= w_enInt;
  end

  assign o_en    = r_en;
  assign o_ack   = w_ack;
  assign o_state = r_state;

endmodule

// File: tb/tb_clk_gate_en_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_gate_en_ctrl
// Scoreboard bench for clk_gate_en_ctrl (default parameters: WAKE_CYC=2,
// RESET_ON=0, IDLE_CNT_W=8).
//
// For every rising edge, the stimulus pushes the hand-computed expected
// state. The monitor pops one entry after each falling edge. At that point
// o_state/o_ack show the last rising edge and o_en shows the enable just
// launched. After each rising edge, the monitor also checks that o_en still
// holds its previous value. A model AND gate checks that every gated clock
// pulse spans a full high phase.
// ---------------------------------------------------------------------------
module tb_clk_gate_en_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       forceOn;
  logic [7:0] idleCfg;
  logic       en;
  logic       ack;
  logic [1:0] state;
  logic       oClk;

  typedef struct {
    logic [1:0] st;
    logic       ack;
    logic       en;
    string      name;
  } exp_t;

  exp_t expQ[$];
  int   nCompared   = 0;
  int   nMismatched = 0;
  bit   glitchArmed = 1'b0;
  time  tRise       = 0;

  clk_gate_en_ctrl #(
    .IDLE_CNT_W(8),
    .WAKE_CYC  (2),
    .RESET_ON  (1'b0)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .i_force_on(forceOn),
    .i_idle_cfg(idleCfg),
    .o_en      (en),
    .o_ack     (ack),
    .o_state   (state)
  );

  // Free-running source clock, period 10.
  always #5 clk = ~clk;

  // Model of the downstream AND clock gate.
  assign oClk = clk & en;

  // Compare an actual value against the required value and log any failure.
  task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] req2);
    nCompared++;
    if (act !== req2) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req2);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the next rising edge.
  task automatic applyStimulus(input logic r, input logic q, input logic f,
                               input logic [7:0] cfg, input logic [1:0] expSt,
                               input string name);
    exp_t e;
    rst     = r;
    req     = q;
    forceOn = f;
    idleCfg = cfg;
    e.st    = expSt;
    e.ack   = (expSt == 2'd2) || (expSt == 2'd3);
    e.en    = (expSt != 2'd0);
    e.name  = name;
    expQ.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: o_en must hold through the high phase; after the falling edge, pop and compare.
  initial begin : monitor
    exp_t m;
    logic lastEn;
    bit   haveLast;
    haveLast = 1'b0;
    lastEn   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (haveLast) checkOutput("en_stable_high_phase", {1'b0, en}, {1'b0, lastEn});
      @(negedge clk);
      #1;
      if (expQ.size() > 0) begin
        m = expQ.pop_front();
        checkOutput({m.name, ".state"}, state, m.st);
        checkOutput({m.name, ".ack"}, {1'b0, ack}, {1'b0, m.ack});
        checkOutput({m.name, ".en"}, {1'b0, en}, {1'b0, m.en});
        lastEn   = m.en;
        haveLast = 1'b1;
      end
    end
  end

  // Record the start of each gated clock pulse.
  always @(posedge oClk) tRise = $time;

  // Every gated clock pulse must last a full i_clk high phase.
  always @(negedge oClk) begin
    if (glitchArmed) begin
      nCompared++;
      if (($time - tRise) != 5) begin
        nMismatched++;
        $display("[TB] FAIL oclk_pulse_width: got %0t, required 5", $time - tRise);
      end
    end
  end

  // Directed stimulus sequence with hand-computed expected states.
  initial begin : stimulus
    rst = 1'b1; req = 1'b0; forceOn = 1'b0; idleCfg = 8'd0;
    #1;
    applyStimulus(1, 0, 0, 0, 0, "reset0");
    applyStimulus(1, 0, 0, 0, 0, "reset1");
    glitchArmed = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0, "off_hold");

    // Wake with i_req: WAKE for two edges, then ON.
    applyStimulus(0, 1, 0, 3, 1, "wake_e1");
    applyStimulus(0, 1, 0, 3, 1, "wake_e2");
    applyStimulus(0, 1, 0, 3, 2, "wake_on");
    applyStimulus(0, 1, 0, 3, 2, "on_hold1");
    applyStimulus(0, 1, 0, 3, 2, "on_hold2");

    // Idle with cfg=3 sampled on entry; later cfg changes are ignored.
    applyStimulus(0, 0, 0, 3, 3, "idle3_e0");
    applyStimulus(0, 0, 0, 0, 3, "idle3_e1");
    applyStimulus(0, 0, 0, 0, 3, "idle3_e2");
    applyStimulus(0, 0, 0, 0, 3, "idle3_e3");
    applyStimulus(0, 0, 0, 0, 0, "idle3_off");
    applyStimulus(0, 0, 0, 0, 0, "off_after_idle");

    // Re-request while idle_cnt=1: straight back to ON, with no ack drop.
    applyStimulus(0, 1, 0, 3, 1, "rewake_e1");
    applyStimulus(0, 1, 0, 3, 1, "rewake_e2");
    applyStimulus(0, 1, 0, 3, 2, "rewake_on");
    applyStimulus(0, 0, 0, 3, 3, "reidle_c3");
    applyStimulus(0, 0, 0, 3, 3, "reidle_c2");
    applyStimulus(0, 0, 0, 3, 3, "reidle_c1");
    applyStimulus(0, 1, 0, 3, 2, "reassert_on");
    applyStimulus(0, 1, 0, 3, 2, "reassert_hold");

    // Leave with cfg=0, then a one-cycle pulse: full WAKE, one ON, one IDLE, OFF.
    applyStimulus(0, 0, 0, 0, 3, "cfg0_idle");
    applyStimulus(0, 0, 0, 0, 0, "cfg0_off");
    applyStimulus(0, 1, 0, 0, 1, "pulse_wake1");
    applyStimulus(0, 0, 0, 0, 1, "pulse_wake2");
    applyStimulus(0, 0, 0, 0, 2, "pulse_on");
    applyStimulus(0, 0, 0, 0, 3, "pulse_idle");
    applyStimulus(0, 0, 0, 0, 0, "pulse_off");
    applyStimulus(0, 0, 0, 0, 0, "pulse_off_hold");

    // Reset during WAKE, then reset during IDLE_WAIT.
    applyStimulus(0, 1, 0, 5, 1, "rstw_wake");
    applyStimulus(1, 1, 0, 5, 0, "rstw_reset");
    applyStimulus(0, 1, 0, 5, 1, "rsti_wake1");
    applyStimulus(0, 1, 0, 5, 1, "rsti_wake2");
    applyStimulus(0, 1, 0, 5, 2, "rsti_on");
    applyStimulus(0, 0, 0, 5, 3, "rsti_idle1");
    applyStimulus(0, 0, 0, 5, 3, "rsti_idle2");
    applyStimulus(1, 0, 0, 5, 0, "rsti_reset");
    applyStimulus(0, 0, 0, 5, 0, "rsti_off");

    // i_force_on alone follows the same path as i_req.
    applyStimulus(0, 0, 1, 1, 1, "force_wake1");
    applyStimulus(0, 0, 1, 1, 1, "force_wake2");
    applyStimulus(0, 0, 1, 1, 2, "force_on");
    applyStimulus(0, 0, 1, 1, 2, "force_hold");
    applyStimulus(0, 0, 0, 1, 3, "force_idle1");
    applyStimulus(0, 0, 0, 1, 3, "force_idle0");
    applyStimulus(0, 0, 0, 1, 0, "force_off");

    // Both requests high together, then force re-entering from IDLE_WAIT.
    applyStimulus(0, 1, 1, 2, 1, "both_wake1");
    applyStimulus(0, 1, 1, 2, 1, "both_wake2");
    applyStimulus(0, 1, 1, 2, 2, "both_on");
    applyStimulus(0, 0, 0, 2, 3, "both_idle2");
    applyStimulus(0, 0, 0, 2, 3, "both_idle1");
    applyStimulus(0, 0, 1, 2, 2, "force_reenter");
    applyStimulus(0, 0, 0, 0, 3, "final_idle");
    applyStimulus(0, 0, 0, 0, 0, "final_off");
    applyStimulus(0, 0, 0, 0, 0, "final_off_hold");

    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(negedge clk);
      #2;
    end
    if (expQ.size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, required 0", expQ.size());
    end
    glitchArmed = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
